// File: rtl/frame_pair_sequencer.sv
// Sequences start pulses, stream checks, pipeline drain and inter-pair gaps for the dual
// frame buffer during multi-pair optical-flow runs.
module frame_pair_sequencer #(
   parameter int unsigned IMAGE_WIDTH    = 320,
   parameter int unsigned IMAGE_HEIGHT   = 240,
   parameter int unsigned MAX_PAIRS      = 16,
   parameter int unsigned DRAIN_CYCLES   = 8,
   parameter int unsigned GAP_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = IMAGE_WIDTH*IMAGE_HEIGHT+64,
   localparam int unsigned PW            = $clog2(MAX_PAIRS+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_start,
   input  logic          cmd_abort,
   input  logic [PW-1:0] num_pairs,
   output logic          fb_start,
   input  logic          fb_pixel_valid,
   input  logic          fb_frame_done,
   input  logic          pipe_busy,
   output logic [PW-1:0] pair_idx,
   output logic          pair_done,
   output logic          busy,
   output logic          seq_done,
   output logic          err_count,
   output logic          err_timeout,
   output logic          aborted
);

   localparam int unsigned FRAME_PIX = IMAGE_WIDTH*IMAGE_HEIGHT;
   localparam int unsigned PXW       = $clog2(FRAME_PIX+2);
   localparam int unsigned TOW       = $clog2(TIMEOUT_CYCLES+2);
   localparam int unsigned DCW       = $clog2(DRAIN_CYCLES+2);
   localparam int unsigned GCW       = $clog2(GAP_CYCLES+2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]     state, state_nxt;
   logic [PW-1:0]  num_pairs_q;
   logic [PXW-1:0] pix_cnt;
   logic [TOW-1:0] to_cnt;
   logic [DCW-1:0] drain_cnt;
   logic [GCW-1:0] gap_cnt;

   logic accept, abort_hit, frame_ok, to_hit, drain_met, gap_met, last_pair;

   assign accept    = (state == S_IDLE) && cmd_start && !cmd_abort;
   assign abort_hit = cmd_abort && (state inside {S_START, S_STREAM, S_DRAIN, S_GAP});
   assign frame_ok  = (pix_cnt == PXW'(FRAME_PIX));
   assign to_hit    = (32'(to_cnt) + 32'd1 >= TIMEOUT_CYCLES);
   assign drain_met = (32'(drain_cnt) + 32'd1 >= DRAIN_CYCLES) && !pipe_busy;
   assign gap_met   = (32'(gap_cnt) + 32'd1 >= GAP_CYCLES);
   assign last_pair = ((pair_idx + PW'(1)) == num_pairs_q);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = (num_pairs == '0) ? S_DONE : S_START;
         S_START:  state_nxt = S_STREAM;
         S_STREAM: begin
            // end-of-frame takes priority over a simultaneous timeout
            if (fb_frame_done)  state_nxt = S_DRAIN;
            else if (to_hit)    state_nxt = S_DONE;
         end
         S_DRAIN:  if (drain_met) state_nxt = last_pair ? S_DONE :
                                              (GAP_CYCLES == 0) ? S_START : S_GAP;
         S_GAP:    if (gap_met) state_nxt = S_START;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_hit) state_nxt = S_DONE;
   end

   // Pulse/level outputs are registered from the next state so they align with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         num_pairs_q <= '0;
         pair_idx    <= '0;
         pix_cnt     <= '0;
         to_cnt      <= '0;
         drain_cnt   <= '0;
         gap_cnt     <= '0;
         fb_start    <= 1'b0;
         pair_done   <= 1'b0;
         busy        <= 1'b0;
         seq_done    <= 1'b0;
         err_count   <= 1'b0;
         err_timeout <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         state     <= state_nxt;
         fb_start  <= (state_nxt == S_START);
         busy      <= (state_nxt != S_IDLE);
         seq_done  <= (state_nxt == S_DONE);
         pair_done <= (state == S_DRAIN) && drain_met && !abort_hit;

         if (accept) begin
            num_pairs_q <= (num_pairs > PW'(MAX_PAIRS)) ? PW'(MAX_PAIRS) : num_pairs;
            pair_idx    <= '0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
            aborted     <= 1'b0;
         end
         if (abort_hit) aborted <= 1'b1;

         if (state_nxt == S_START && (state == S_DRAIN || state == S_GAP))
            pair_idx <= pair_idx + PW'(1);

         if (state == S_START) begin
            pix_cnt <= '0;
            to_cnt  <= '0;
         end else if (state == S_STREAM) begin
            if (fb_pixel_valid && !fb_frame_done && pix_cnt != PXW'(FRAME_PIX+1))
               pix_cnt <= pix_cnt + PXW'(1);
            if (32'(to_cnt) < TIMEOUT_CYCLES)
               to_cnt <= to_cnt + TOW'(1);
            if (!abort_hit) begin
               if (fb_frame_done) begin
                  if (!frame_ok) err_count <= 1'b1;
               end else if (to_hit) begin
                  err_timeout <= 1'b1;
               end
            end
         end

         if (state == S_DRAIN) begin
            if (32'(drain_cnt) < DRAIN_CYCLES) drain_cnt <= drain_cnt + DCW'(1);
         end else begin
            drain_cnt <= '0;
         end

         if (state == S_GAP) begin
            if (32'(gap_cnt) < GAP_CYCLES) gap_cnt <= gap_cnt + GCW'(1);
         end else begin
            gap_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_frame_pair_sequencer.sv
// Directed bench for frame_pair_sequencer on a 4x4 image, drain 8, gap 4, timeout 20.
module tb_frame_pair_sequencer;

   localparam int unsigned PW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_start = 1'b0;
   logic          cmd_abort = 1'b0;
   logic [PW-1:0] num_pairs = '0;
   logic          fb_start;
   logic          fb_pixel_valid = 1'b0;
   logic          fb_frame_done = 1'b0;
   logic          pipe_busy = 1'b0;
   logic [PW-1:0] pair_idx;
   logic          pair_done, busy, seq_done, err_count, err_timeout, aborted;

   int checks = 0;
   int failures = 0;
   int n_fb_start = 0, n_pair_done = 0, n_seq_done = 0;

   frame_pair_sequencer #(
      .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .MAX_PAIRS(4),
      .DRAIN_CYCLES(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .num_pairs(num_pairs), .fb_start(fb_start), .fb_pixel_valid(fb_pixel_valid),
      .fb_frame_done(fb_frame_done), .pipe_busy(pipe_busy), .pair_idx(pair_idx),
      .pair_done(pair_done), .busy(busy), .seq_done(seq_done), .err_count(err_count),
      .err_timeout(err_timeout), .aborted(aborted)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         n_fb_start  <= n_fb_start + int'(fb_start);
         n_pair_done <= n_pair_done + int'(pair_done);
         n_seq_done  <= n_seq_done + int'(seq_done);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({fb_start, pair_done, busy, seq_done, err_count, err_timeout, aborted, pair_idx});
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_run(input int np);
      @(negedge clk);
      cmd_start = 1'b1;
      num_pairs = PW'(np);
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic wait_fb_start(output int n);
      n = 0;
      while (!fb_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!fb_start) check("fb_start_wait", 0, 1);
   endtask

   // Returns at the first DRAIN-cycle negedge.
   task automatic stream(input int npx);
      @(negedge clk);
      for (int i = 0; i < npx; i++) begin
         fb_pixel_valid = 1'b1;
         @(negedge clk);
      end
      fb_pixel_valid = 1'b0;
      fb_frame_done  = 1'b1;
      @(negedge clk);
      fb_frame_done  = 1'b0;
   endtask

   // lat counts cycles from DRAIN entry to pair_done; pipe_busy drops when lat reaches hold.
   task automatic wait_pair_done(input int hold, output int lat);
      lat = 0;
      while (!pair_done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == hold) pipe_busy = 1'b0;
      end
      if (!pair_done) check("pair_done_wait", 0, 1);
   endtask

   task automatic wait_seq_done(output int n);
      n = 0;
      while (!seq_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!seq_done) check("seq_done_wait", 0, 1);
   endtask

   int n, lat, b_fs, b_pd, b_sd;

   initial begin
      idle(3);
      check("reset_outputs", all_outs(), 0);
      rst_n = 1'b1;
      idle(2);
      check("idle_outputs", all_outs(), 0);

      // Two clean pairs
      b_fs = n_fb_start; b_pd = n_pair_done; b_sd = n_seq_done;
      start_run(2);
      wait_fb_start(n);
      check("t1_start_lat", n, 0);
      check("t1_idx0", int'(pair_idx), 0);
      stream(16);
      wait_pair_done(0, lat);
      check("t1_drain_lat0", lat, 8);
      wait_fb_start(n);
      check("t1_gap", n, 4);
      check("t1_idx1", int'(pair_idx), 1);
      stream(16);
      wait_pair_done(0, lat);
      check("t1_drain_lat1", lat, 8);
      check("t1_seq_with_last", int'(seq_done), 1);
      idle(2);
      check("t1_fb_starts", n_fb_start - b_fs, 2);
      check("t1_pair_dones", n_pair_done - b_pd, 2);
      check("t1_seq_dones", n_seq_done - b_sd, 1);
      check("t1_errs", int'({err_count, err_timeout, aborted}), 0);
      check("t1_idx_hold", int'(pair_idx), 1);
      check("t1_busy_low", int'(busy), 0);

      // Zero pairs
      b_fs = n_fb_start;
      start_run(0);
      check("t2_seq_done", int'(seq_done), 1);
      check("t2_busy", int'(busy), 1);
      @(negedge clk);
      check("t2_seq_end", int'(seq_done), 0);
      check("t2_busy_end", int'(busy), 0);
      idle(2);
      check("t2_no_fb_start", n_fb_start - b_fs, 0);

      // Short frame on pair 0
      b_pd = n_pair_done;
      start_run(2);
      wait_fb_start(n);
      stream(15);
      check("t3_err_set", int'(err_count), 1);
      wait_pair_done(0, lat);
      wait_fb_start(n);
      stream(16);
      wait_pair_done(0, lat);
      wait_seq_done(n);
      idle(2);
      check("t3_pairs_done", n_pair_done - b_pd, 2);
      check("t3_err_sticky", int'(err_count), 1);
      start_run(1);
      check("t3_err_cleared", int'(err_count), 0);
      wait_fb_start(n);
      stream(16);
      wait_pair_done(0, lat);
      idle(2);
      check("t3_err_clean", int'(err_count), 0);

      // Slow pipeline holds DRAIN
      start_run(1);
      wait_fb_start(n);
      pipe_busy = 1'b1;
      stream(16);
      wait_pair_done(30, lat);
      check("t5_busy_hold_lat", lat, 31);
      idle(2);

      // Missing end-of-frame
      b_pd = n_pair_done;
      start_run(1);
      wait_fb_start(n);
      @(negedge clk);
      n = 1;
      while (!seq_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_timeout_cycle", n, 21);
      check("t4_err_timeout", int'(err_timeout), 1);
      check("t4_err_count", int'(err_count), 0);
      idle(2);
      check("t4_no_pair_done", n_pair_done - b_pd, 0);

      // Abort in GAP of pair 0
      b_fs = n_fb_start; b_pd = n_pair_done;
      start_run(3);
      wait_fb_start(n);
      stream(16);
      wait_pair_done(0, lat);
      @(negedge clk);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      check("t6_aborted", int'(aborted), 1);
      check("t6_seq_done", int'(seq_done), 1);
      check("t6_idx", int'(pair_idx), 0);
      @(negedge clk);
      check("t6_busy_low", int'(busy), 0);
      idle(2);
      check("t6_fb_starts", n_fb_start - b_fs, 1);
      check("t6_pair_dones", n_pair_done - b_pd, 1);

      // Reset mid-STREAM
      start_run(1);
      wait_fb_start(n);
      @(negedge clk);
      fb_pixel_valid = 1'b1;
      idle(3);
      check("t6_busy_streaming", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t6_reset_outputs", all_outs(), 0);
      @(negedge clk);
      fb_pixel_valid = 1'b0;
      rst_n = 1'b1;
      idle(3);
      check("t6_post_reset_idle", all_outs(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
